// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the multi-port register file
package regfile_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters, issue gating and busy lookup (REGFILE_BYPASS_EN: busy shows post-update count on write hits)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int SB_W = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [ADDR_W-1:0]        clr_idx,
  input  logic [NUM_WR-1:0]        wr_act,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     iss_ready
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [SB_W-1:0] cnt [DEPTH];
  logic [SB_W-1:0] cnt_next [DEPTH];
  logic [SB_W:0] up, dn;
  logic [ADDR_W-1:0] ra;
  logic hit;
  logic [SB_W-1:0] rc;
  assign iss_ready = run && ((ZERO_REG != 0 && iss_addr == ADDR_W'(REG_ZERO)) || cnt[iss_addr] != '1);
  // next count per register: accepted issue adds one, each writeback removes one, floored at zero
  always_comb begin
    up = '0;
    dn = '0;
    for (int r = 0; r < DEPTH; r++) begin
      up = {1'b0, cnt[r]} + (SB_W+1)'(iss_en && iss_ready && iss_addr == ADDR_W'(r));
      dn = '0;
      for (int w = 0; w < NUM_WR; w++)
        dn = dn + (SB_W+1)'(wr_act[w] && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r));
      cnt_next[r] = (ZERO_REG != 0 && r == REG_ZERO) ? '0 : (up < dn) ? '0 : SB_W'(up - dn);
    end
  end
  // counters are wiped one entry per cycle while clearing, otherwise all advance together
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) cnt[clr_idx] <= '0;
      else for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_next[r];
    end
  end
  // busy lookup per read port, using the post-update count when forwarding a write
  always_comb begin
    rd_busy = '0;
    ra = '0;
    hit = 1'b0;
    rc = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) hit = hit | (wr_act[w] && wr_addr[w*ADDR_W +: ADDR_W] == ra);
`endif
      rc = hit ? cnt_next[ra] : cnt[ra];
      rd_busy[k] = run && !(ZERO_REG != 0 && ra == ADDR_W'(REG_ZERO)) && rc != '0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with zero register, pending-write scoreboard and sequential clear (REGFILE_BYPASS_EN: same-cycle write forwarding)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int SB_W = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic                     init_done
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_idx, clr_idx_n;
  logic run;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_WR-1:0] wr_act;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  assign run = state == ST_RUN;
  assign init_done = run;
  // state and clear pointer; reset always restarts the wipe from entry 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= clr_idx_n;
    end
  end
  // clear walks every entry once, then hands over to normal operation
  always_comb begin
    state_n = (state == ST_CLEAR && clr_idx == '1) ? ST_RUN : state;
    clr_idx_n = (state == ST_CLEAR) ? clr_idx + 1'b1 : clr_idx;
  end
  // effective write strobes: only while running and never to the hardwired zero register
  always_comb begin
    wr_act = '0;
    for (int w = 0; w < NUM_WR; w++)
      wr_act[w] = run && wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO));
  end
  // storage: clear one entry per cycle, or apply writes in port order so the highest port wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) regs[clr_idx] <= '0;
      else
        for (int w = 0; w < NUM_WR; w++)
          if (wr_act[w]) regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
    end
  end
  // combinational read ports, forced to zero while clearing or for the zero register
  always_comb begin
    rd_data = '0;
    ra = '0;
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++)
        if (wr_act[w] && wr_addr[w*ADDR_W +: ADDR_W] == ra) rd = wr_data[w*DATA_W +: DATA_W];
`endif
      rd_data[k*DATA_W +: DATA_W] = (!run || (ZERO_REG != 0 && ra == ADDR_W'(REG_ZERO))) ? '0 : rd;
    end
  end
  regfile_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .SB_W(SB_W), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk), .reset(reset), .run(run), .clr_idx(clr_idx),
    .wr_act(wr_act), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr(rd_addr), .rd_busy(rd_busy), .iss_ready(iss_ready)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench with a behavioural register-file model checked every cycle
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, SW = 2, D = 32;
  localparam int CMAX = (1 << SW) - 1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic [NW-1:0] wr_en = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic iss_en = 0;
  logic [AW-1:0] iss_addr = '0;
  logic iss_ready, init_done;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .SB_W(SW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready), .init_done(init_done)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: register values, pending counts, clear progress
  logic [DW-1:0] m_reg [D];
  int m_cnt [D];
  bit m_known = 0, m_clear = 0;
  int m_left = 0;

  function automatic int waddr(int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction
  function automatic bit hit(int w, int r);
    return wr_en[w] && waddr(w) == r && r != 0;
  endfunction
  function automatic bit exp_ready();
    return !m_clear && (iss_addr == 0 || m_cnt[iss_addr] < CMAX);
  endfunction
  function automatic int cnt_after(int r);
    int n;
    if (r == 0) return 0;
    n = m_cnt[r] + ((iss_en && exp_ready() && int'(iss_addr) == r) ? 1 : 0);
    for (int w = 0; w < NW; w++) n -= int'(hit(w, r));
    return (n < 0) ? 0 : n;
  endfunction

  always @(posedge clk) begin
    int nc [D];
    if (reset) begin
      m_known = 1;
      m_clear = 1;
      m_left = D;
    end else if (m_known && m_clear) begin
      m_left--;
      if (m_left == 0) begin
        m_clear = 0;
        for (int r = 0; r < D; r++) begin
          m_reg[r] = '0;
          m_cnt[r] = 0;
        end
      end
    end else if (m_known) begin
      for (int r = 0; r < D; r++) nc[r] = cnt_after(r);
      for (int w = 0; w < NW; w++) if (hit(w, waddr(w))) m_reg[waddr(w)] = wr_data[w*DW +: DW];
      for (int r = 0; r < D; r++) m_cnt[r] = nc[r];
    end
  end

  always @(negedge clk) begin
    int a, c;
    logic [DW-1:0] d;
    if (m_known) begin
      chk("init_done", init_done, !m_clear);
      chk("iss_ready", iss_ready, exp_ready());
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        d = m_reg[a];
        c = m_cnt[a];
        if (BYP)
          for (int w = 0; w < NW; w++)
            if (hit(w, a)) begin
              d = wr_data[w*DW +: DW];
              c = cnt_after(a);
            end
        if (m_clear || a == 0) begin
          d = '0;
          c = 0;
        end
        chk($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], d);
        chk($sformatf("rd_busy%0d", k), rd_busy[k], c != 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    wr_en = '0;
    iss_en = 0;
  endtask
  task automatic wr(int p, int a, logic [DW-1:0] dv);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = dv;
  endtask
  task automatic rdp(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic do_reset;
    reset = 1;
    tick;
    reset = 0;
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1;
    tick;
    do_reset;
    chk("init_low_after_reset", init_done, 0);
    wait_init(n);
    chk("init_len", n, 32);
    for (int i = 1; i < D; i++) begin
      wr(0, i, 32'hA500_0000 | DW'(i));
      rdp(1, i - 1);
      tick;
      idle;
    end
    rdp(0, 31);
    #1;
    chk("prefill_r31", rd_data[DW-1:0], 32'hA500_001F);
    do_reset;
    wait_init(n);
    chk("init_len2", n, 32);
    for (int i = 0; i < D; i += 2) begin
      rdp(0, i);
      rdp(1, i + 1);
      #1;
      chk("cleared_p0", rd_data[DW-1:0], 0);
      chk("cleared_p1", rd_data[2*DW-1:DW], 0);
      tick;
    end
    rdp(0, 5);
    wr(0, 5, 32'hDEAD_BEEF);
    #1;
    chk("r5_same_cycle", rd_data[DW-1:0], BYP ? 32'hDEAD_BEEF : 32'h0);
    tick;
    idle;
    #1;
    chk("r5_next_cycle", rd_data[DW-1:0], 32'hDEAD_BEEF);
    wr(0, 0, 32'h1234);
    rdp(0, 0);
    tick;
    idle;
    #1;
    chk("r0_data", rd_data[DW-1:0], 0);
    chk("r0_busy", rd_busy[0], 0);
    iss_addr = 0;
    iss_en = 1;
    #1;
    chk("r0_iss_ready", iss_ready, 1);
    tick;
    idle;
    #1;
    chk("r0_busy_after_iss", rd_busy[0], 0);
    chk("r0_ready_after_iss", iss_ready, 1);
    wr(0, 7, 32'h1);
    rdp(0, 7);
    tick;
    idle;
    #1;
    chk("clamp_idle_wb", rd_busy[0], 0);
    iss_addr = 7;
    iss_en = 1;
    tick;
    idle;
    #1;
    chk("clamp_one_issue", rd_busy[0], 1);
    wr(0, 7, 32'h2);
    tick;
    idle;
    #1;
    chk("clamp_back_zero", rd_busy[0], 0);
    iss_en = 1;
    repeat (3) tick;
    #1;
    chk("sat_busy", rd_busy[0], 1);
    chk("sat_not_ready", iss_ready, 0);
    tick;
    idle;
    repeat (2) begin
      wr(0, 7, 32'h7);
      tick;
    end
    idle;
    #1;
    chk("sat_after_2wb", rd_busy[0], 1);
    wr(1, 7, 32'h8);
    tick;
    idle;
    #1;
    chk("sat_after_3wb", rd_busy[0], 0);
    iss_addr = 9;
    iss_en = 1;
    repeat (2) tick;
    wr(0, 9, 32'h11);
    wr(1, 9, 32'h22);
    rdp(0, 9);
    tick;
    idle;
    #1;
    chk("conflict_data", rd_data[DW-1:0], 32'h22);
    chk("conflict_busy", rd_busy[0], 1);
    wr(1, 9, 32'h33);
    tick;
    idle;
    #1;
    chk("conflict_final_busy", rd_busy[0], 0);
    chk("conflict_final_data", rd_data[DW-1:0], 32'h33);
    wr(0, 3, 32'h0303);
    wr(1, 4, 32'h0404);
    rdp(0, 3);
    rdp(1, 4);
    tick;
    idle;
    #1;
    chk("dual_p0", rd_data[DW-1:0], 32'h0303);
    chk("dual_p1", rd_data[2*DW-1:DW], 32'h0404);
    do_reset;
    repeat (10) tick;
    chk("midclear_low", init_done, 0);
    do_reset;
    wait_init(n);
    chk("restart_len", n, 32);
    #1;
    chk("restart_r3", rd_data[DW-1:0], 0);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core; replaces the fixed 32x32, 2-read/1-write file between the decode and writeback stages.
- Adds configurable read/write port counts, a hardwired zero register, and a per-register pending-write scoreboard used by the hazard unit to stall.
- Adds a sequential clear engine, so reset does not rely on a single-cycle array wipe.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of combinational read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- SB_W, 2, width of each register's pending-write counter.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; starts the clear sequence.
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  out  NUM_RD  1 when the addressed register has pending writes (counter != 0).
- wr_en  in  NUM_WR  writeback strobes.
- wr_addr  in  NUM_WR*ADDR_W  writeback indices.
- wr_data  in  NUM_WR*DATA_W  writeback data.
- iss_en  in  1  instruction issued with destination iss_addr; increments its counter.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- iss_ready  out  1  0 when the counter of iss_addr is saturated (all ones); issue must wait.
- init_done  out  1  1 once the clear sequence has completed.

Behaviour:
- FSM states CLEAR and RUN. reset=1 at a clock edge forces CLEAR with clr_idx=0, including when already in CLEAR or mid-operation.
- CLEAR: each cycle zeroes registers[clr_idx] and sb_cnt[clr_idx], then increments clr_idx. After clearing DEPTH-1, next state is RUN. The sequence takes DEPTH cycles after reset deasserts.
- In CLEAR: wr_en and iss_en are ignored, rd_data=0, rd_busy=0, iss_ready=0, init_done=0.
- RUN: init_done=1. Writes take effect at the clock edge. Reads are combinational from the array (bypass: see Optional Feature).
- Write conflict: if two write ports target the same register in one cycle, the higher-indexed port wins.
- Scoreboard counter for register r, per cycle, with inc = iss_en and iss_addr==r, and dec = number of write ports writing r:
  - new value = cnt + inc - dec;
  - never decrements below 0 (a spurious writeback to an idle register leaves it at 0);
  - iss_en with iss_ready=0 is ignored;
  - simultaneous issue and writeback to the same register leave the count unchanged.
- ZERO_REG=1: register 0 reads 0, and writes, issues and counter updates to index 0 are dropped; rd_busy for index 0 is 0; iss_ready for iss_addr=0 is 1.
- Reset values: all registers and counters 0 after CLEAR, rd_data=0, rd_busy=0, iss_ready=0, init_done=0.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: in RUN, a read port whose address matches an active write port (honouring port priority) returns wr_data in the same cycle, and rd_busy for that port reflects the post-update counter.
- Not defined: reads return the pre-edge array value and the pre-edge counter. The decode stage must then cover the write-read overlap with one extra stall.

Decomposition:
- Package regfile_pkg holds:
  - the state enum {ST_CLEAR, ST_RUN};
  - the default DATA_W/ADDR_W constants;
  - the localparam REG_ZERO = 0.
- One natural sub-module, regfile_scoreboard: the counter array, iss_ready and busy lookup. Array storage, clear FSM and bypass muxing stay in the top level.

Test Plan:
- Reset, DEPTH=32: init_done=0 for exactly 32 cycles after reset falls, then 1. Registers prefilled before reset all read 0 afterwards.
- Write r5=0xDEADBEEF, read r5 next cycle: 0xDEADBEEF.
  - Same-cycle read with REGFILE_BYPASS_EN: 0xDEADBEEF.
  - Same-cycle read without it: previous value 0.
- Write r0=0x1234 with ZERO_REG=1: r0 reads 0, rd_busy=0. Issue to r0: iss_ready stays 1, counter unchanged.
- Issue r7 three times with SB_W=2: rd_busy=1, iss_ready=0 at count 3. Fourth issue is ignored. Three writebacks return busy to 0.
- NUM_WR=2, both ports write r9 (0x11, 0x22): r9=0x22. Same cycle iss_en r9 with count 2 gives final count 1.
- Assert reset mid-CLEAR at clr_idx=10: sequence restarts and init_done rises 32 cycles after reset deasserts.
